// File: rtl/ocx_tlx_fifo_rd_arb.sv
// Purpose : round-robin read scheduler sharing one downstream consumer among NUM_REQ FIFO controllers.
// Latency : 0 cycles from fifo_data_available_i to fifo_rd_done_o/dn_valid_o; credit_cnt_o updates one cycle later.
// Backpres: issue stalls while the downstream credit pool is empty; the owner keeps its burst slot while stalled.
//
// Ports:
//   clock_i                  sole clock, rising edge
//   reset_i                  synchronous, active-high
//   fifo_data_available_i    per-FIFO data-available flags
//   credit_return_i          one-cycle pulse, one downstream credit returned
//   fifo_rd_done_o           one-hot-or-zero pop strobe per FIFO
//   dn_valid_o               an entry is transferred this cycle
//   dn_id_o                  index of the popped FIFO (0 when idle)
//   credit_cnt_o             registered credit count
//   credit_overflow_error_o  credit returned while the pool is already full and nothing popped
module ocx_tlx_fifo_rd_arb #(
    parameter int NUM_REQ      = 4,
    parameter int ID_WIDTH     = 2,
    parameter int CREDIT_WIDTH = 4,
    parameter int INIT_CREDITS = 8,
    parameter int MAX_BURST    = 4,
    parameter int BURST_WIDTH  = 3
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      fifo_data_available_i,
    input  logic                    credit_return_i,
    output logic [NUM_REQ-1:0]      fifo_rd_done_o,
    output logic                    dn_valid_o,
    output logic [ID_WIDTH-1:0]     dn_id_o,
    output logic [CREDIT_WIDTH-1:0] credit_cnt_o,
    output logic                    credit_overflow_error_o
);

    localparam int SW = ID_WIDTH + 1;
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_INIT = CREDIT_WIDTH'(INIT_CREDITS);
    localparam logic [BURST_WIDTH-1:0]  BURST_MAX   = BURST_WIDTH'(MAX_BURST);
    localparam logic [ID_WIDTH-1:0]     LAST_INIT   = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     owner_q, owner_d;
    logic [ID_WIDTH-1:0]     last_q, last_d;
    logic [BURST_WIDTH-1:0]  burst_cnt_q, burst_cnt_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;

    logic                    credit_ok;
    logic [ID_WIDTH-1:0]     arb_start;
    logic                    arb_found;
    logic [ID_WIDTH-1:0]     arb_grant;
    logic [SW-1:0]           scan_idx;
    logic                    pop_vld;
    logic [ID_WIDTH-1:0]     pop_id;
    logic                    credit_err;

    // A credit returned this cycle only becomes usable next cycle.
    assign credit_ok = (credit_q != '0);

    // In BURST the scan starts after the owner; in IDLE after the last grant.
    // The two are equal whenever a burst is active, so this is purely for clarity.
    assign arb_start = (state_q == BURST) ? owner_q : last_q;

    // Scan start+1 .. start+NUM_REQ, wrapping at NUM_REQ. The final step lands on
    // start itself, which lets a lone owner re-win after its burst limit.
    always_comb begin
        arb_found = 1'b0;
        arb_grant = '0;
        scan_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = {1'b0, arb_start} + SW'(i);
            if (scan_idx >= SW'(NUM_REQ)) begin
                scan_idx = scan_idx - SW'(NUM_REQ);
            end
            if (!arb_found && fifo_data_available_i[scan_idx[ID_WIDTH-1:0]]) begin
                arb_found = 1'b1;
                arb_grant = scan_idx[ID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        pop_vld     = 1'b0;
        pop_id      = '0;
        case (state_q)
            IDLE: begin
                if (credit_ok && arb_found) begin
                    pop_vld     = 1'b1;
                    pop_id      = arb_grant;
                    owner_d     = arb_grant;
                    last_d      = arb_grant;
                    burst_cnt_d = BURST_WIDTH'(1);
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (!credit_ok) begin
                    // Stalled on credits: keep ownership and burst position.
                    state_d = BURST;
                end else if (fifo_data_available_i[owner_q] && (burst_cnt_q < BURST_MAX)) begin
                    pop_vld     = 1'b1;
                    pop_id      = owner_q;
                    burst_cnt_d = burst_cnt_q + BURST_WIDTH'(1);
                end else if (arb_found) begin
                    pop_vld     = 1'b1;
                    pop_id      = arb_grant;
                    owner_d     = arb_grant;
                    last_d      = arb_grant;
                    burst_cnt_d = BURST_WIDTH'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A return into a full pool with no matching pop is dropped and flagged.
    always_comb begin
        credit_err = credit_return_i && !pop_vld && (credit_q == CREDIT_INIT);
        credit_d   = credit_q;
        if (!credit_err) begin
            credit_d = credit_q - CREDIT_WIDTH'(pop_vld) + CREDIT_WIDTH'(credit_return_i);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= LAST_INIT;
            burst_cnt_q <= '0;
            credit_q    <= CREDIT_INIT;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            credit_q    <= credit_d;
        end
    end

    always_comb begin
        fifo_rd_done_o = '0;
        if (pop_vld) begin
            fifo_rd_done_o[pop_id] = 1'b1;
        end
    end

    assign dn_valid_o              = pop_vld;
    assign dn_id_o                 = pop_vld ? pop_id : '0;
    assign credit_cnt_o            = credit_q;
    assign credit_overflow_error_o = credit_err;

endmodule

// File: tb/tb_ocx_tlx_fifo_rd_arb.sv
// Purpose : directed self-checking bench for the round-robin FIFO read scheduler.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpres: credit returns are driven explicitly per vector.
module tb_ocx_tlx_fifo_rd_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] avail, avail_rr;
    logic       ret, ret_rr;

    logic [3:0] rd_done, rd_done_rr;
    logic       dn_vld, dn_vld_rr;
    logic [1:0] dn_id, dn_id_rr;
    logic [3:0] credit_cnt, credit_cnt_rr;
    logic       err, err_rr;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ocx_tlx_fifo_rd_arb #(
        .NUM_REQ(4), .ID_WIDTH(2), .CREDIT_WIDTH(4), .INIT_CREDITS(8),
        .MAX_BURST(4), .BURST_WIDTH(3)
    ) dut (
        .clock_i                 (clk),
        .reset_i                 (rst),
        .fifo_data_available_i   (avail),
        .credit_return_i         (ret),
        .fifo_rd_done_o          (rd_done),
        .dn_valid_o              (dn_vld),
        .dn_id_o                 (dn_id),
        .credit_cnt_o            (credit_cnt),
        .credit_overflow_error_o (err)
    );

    ocx_tlx_fifo_rd_arb #(
        .NUM_REQ(4), .ID_WIDTH(2), .CREDIT_WIDTH(4), .INIT_CREDITS(8),
        .MAX_BURST(1), .BURST_WIDTH(3)
    ) dut_rr (
        .clock_i                 (clk),
        .reset_i                 (rst),
        .fifo_data_available_i   (avail_rr),
        .credit_return_i         (ret_rr),
        .fifo_rd_done_o          (rd_done_rr),
        .dn_valid_o              (dn_vld_rr),
        .dn_id_o                 (dn_id_rr),
        .credit_cnt_o            (credit_cnt_rr),
        .credit_overflow_error_o (err_rr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        avail    = '0;
        ret      = 1'b0;
        avail_rr = '0;
        ret_rr   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int e_rr[4];
        int e_join[3];
        e_rr   = '{1, 3, 1, 3};
        e_join = '{0, 1, 3};

        rst = 1'b1; avail = '0; ret = 1'b0; avail_rr = '0; ret_rr = 1'b0;

        // Reset state
        do_reset();
        smp();
        chk("rst_vld",     32'(dn_vld),     32'(0));
        chk("rst_rd_done", 32'(rd_done),    32'(0));
        chk("rst_id",      32'(dn_id),      32'(0));
        chk("rst_credit",  32'(credit_cnt), 32'(8));
        chk("rst_err",     32'(err),        32'(0));
        chk("rst_rr_vld",  32'(dn_vld_rr),  32'(0));
        tick();

        // FIFO 2 holds three entries: pops in cycles 0..2, none in cycle 3
        for (int c = 0; c < 4; c++) begin
            avail = (c < 3) ? 4'b0100 : 4'b0000;
            smp();
            chk("t1_vld", 32'(dn_vld), 32'(c < 3));
            if (c < 3) begin
                chk("t1_id",      32'(dn_id),   32'(2));
                chk("t1_rd_done", 32'(rd_done), 32'(4'b0100));
            end
            if (c == 0) chk("t1_credit0", 32'(credit_cnt), 32'(8));
            if (c == 3) chk("t1_credit3", 32'(credit_cnt), 32'(5));
            tick();
        end

        // All four FIFOs busy, credits refilled each cycle: bursts of four
        do_reset();
        for (int c = 0; c < 20; c++) begin
            avail = 4'hF;
            ret   = 1'b1;
            smp();
            chk("t2_vld", 32'(dn_vld), 32'(1));
            chk("t2_id",  32'(dn_id),  32'((c / 4) % 4));
            chk("t2_err", 32'(err),    32'(0));
            tick();
        end
        avail = '0;
        ret   = 1'b0;
        smp();
        chk("t2_credit", 32'(credit_cnt), 32'(8));
        tick();

        // MAX_BURST=1: FIFOs 1 and 3 alternate, then FIFO 0 joins
        do_reset();
        for (int c = 0; c < 4; c++) begin
            avail_rr = 4'b1010;
            ret_rr   = 1'b1;
            smp();
            chk("t3_rr_id", 32'(dn_id_rr), 32'(e_rr[c]));
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            avail_rr = 4'b1011;
            ret_rr   = 1'b1;
            smp();
            chk("t3_join_id", 32'(dn_id_rr), 32'(e_join[c]));
            tick();
        end
        avail_rr = '0;
        ret_rr   = 1'b0;

        // Credit exhaustion: eight pops, stall, one return gives one pop next cycle
        do_reset();
        for (int c = 0; c < 13; c++) begin
            avail = 4'b0001;
            ret   = (c == 10);
            smp();
            chk("t4_vld", 32'(dn_vld), 32'((c < 8) || (c == 11)));
            if (c == 8)  chk("t4_credit8",  32'(credit_cnt), 32'(0));
            if (c == 11) chk("t4_credit11", 32'(credit_cnt), 32'(1));
            if (c == 12) chk("t4_credit12", 32'(credit_cnt), 32'(0));
            tick();
        end

        // Credit overflow with an idle downstream, then return+pop at full pool
        do_reset();
        ret = 1'b1; avail = '0;
        smp();
        chk("t5_err_on",  32'(err),        32'(1));
        chk("t5_credit",  32'(credit_cnt), 32'(8));
        tick();
        ret = 1'b0;
        smp();
        chk("t5_err_off", 32'(err),        32'(0));
        chk("t5_hold",    32'(credit_cnt), 32'(8));
        tick();
        ret = 1'b1; avail = 4'b0001;
        smp();
        chk("t5_pop_err", 32'(err),    32'(0));
        chk("t5_pop_vld", 32'(dn_vld), 32'(1));
        tick();
        ret = 1'b0; avail = '0;
        smp();
        chk("t5_pop_credit", 32'(credit_cnt), 32'(8));
        tick();

        // Reset mid-burst (owner 3, burst count 2, three credits left)
        do_reset();
        for (int c = 0; c < 6; c++) begin
            avail = (c < 4) ? 4'b0010 : 4'b1000;
            ret   = (c == 5);
            smp();
            chk("t6_id", 32'(dn_id), 32'((c < 4) ? 1 : 3));
            tick();
        end
        rst = 1'b1; avail = '0; ret = 1'b0;
        smp();
        chk("t6_pre_credit", 32'(credit_cnt), 32'(3));
        tick();
        rst = 1'b0;
        smp();
        chk("t6_post_vld",     32'(dn_vld),     32'(0));
        chk("t6_post_rd_done", 32'(rd_done),    32'(0));
        chk("t6_post_credit",  32'(credit_cnt), 32'(8));
        tick();
        avail = 4'b1100;
        smp();
        chk("t6_first_id",  32'(dn_id),  32'(2));
        chk("t6_first_vld", 32'(dn_vld), 32'(1));
        tick();
        avail = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ocx_tlx_fifo_rd_arb.md
# ocx_tlx_fifo_rd_arb

Round-robin read scheduler that shares one downstream consumer among NUM_REQ `ocx_tlx_fifo_cntlr` instances in the TLX receive path. Each cycle it selects at most one FIFO with data available and pulses that FIFO's `fifo_rd_done`. Issue is gated by a shared downstream credit pool. A burst limit lets the current owner drain back-to-back entries before ownership rotates.

## Interface
- NUM_REQ, 4, number of FIFO controllers arbitrated (2..2^ID_WIDTH)
- ID_WIDTH, 2, width of requester index
- CREDIT_WIDTH, 4, width of credit counter; must hold INIT_CREDITS
- INIT_CREDITS, 8, credits loaded at reset (1..2^CREDIT_WIDTH-1)
- MAX_BURST, 4, max consecutive pops per ownership (1..2^BURST_WIDTH-1)
- BURST_WIDTH, 3, width of burst counter
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- fifo_data_available  in  NUM_REQ  per-FIFO registered data-available from each controller
- credit_return  in  1  one-cycle pulse; downstream returns one credit
- fifo_rd_done  out  NUM_REQ  one-hot-or-zero pop strobe to each controller
- dn_valid  out  1  entry transferred this cycle (OR of fifo_rd_done)
- dn_id  out  ID_WIDTH  index of popped FIFO; 0 when dn_valid=0
- credit_cnt  out  CREDIT_WIDTH  current credits (registered)
- credit_overflow_error  out  1  credit_return while credit_cnt==INIT_CREDITS and no pop

## Operation
- State registers: owner_q (ID_WIDTH), burst_cnt_q (BURST_WIDTH), last_q (ID_WIDTH), credit_q, state_q in {IDLE, BURST}.
- Issue allowed only if credit_q != 0. A same-cycle credit_return does not enable issue.
- IDLE: if issue allowed and any available bit is set, grant the first set bit scanning last_q+1, last_q+2, ... mod NUM_REQ (wrap at NUM_REQ, not 2^ID_WIDTH). Then owner_q<=grant, last_q<=grant, burst_cnt_q<=1, go to BURST. Otherwise stay in IDLE.
- BURST: if issue allowed, available[owner_q]=1 and burst_cnt_q<MAX_BURST, pop owner_q again, burst_cnt_q+1, and stay in BURST.
- BURST, other cases:
  - If the owner is empty or burst_cnt_q==MAX_BURST, perform the IDLE arbitration in the same cycle, starting after owner_q. If another requester wins, do the same updates as IDLE. If nothing wins, go to IDLE.
  - If the owner is the only requester, it re-wins with burst_cnt_q<=1.
- BURST with no credit: hold owner_q and burst_cnt_q, issue nothing, stay in BURST.
- fifo_rd_done is combinational from registered state, fifo_data_available and credit_q. It never has more than one bit set. The pop is never asserted toward a FIFO whose available bit is 0, so the controller never underflows.
- Credits: credit_d = credit_q - dn_valid + credit_return.
  - When credit_return=1, dn_valid=0 and credit_q==INIT_CREDITS, the counter holds and credit_overflow_error pulses for that cycle.
  - Pop and return in the same cycle leave the counter unchanged.
- MAX_BURST=1 degenerates to pure round-robin.

## Timing
- Reset values: all outputs 0 except credit_cnt=INIT_CREDITS. State registers reset to state_q=IDLE, owner_q=0, burst_cnt_q=0, last_q=NUM_REQ-1, so the first grant scans from index 0.
- Latency: available bit high at cycle t with credit -> fifo_rd_done/dn_valid/dn_id in cycle t (0 cycles).
- The controller's fifo_data_available at t+1 already reflects the pop at t, so back-to-back pops of one FIFO at full rate are legal.
- credit_cnt updates the cycle after the pop/return.
- Reset asserted mid-burst: in the next cycle all outputs are 0 and credits are reloaded. In-flight credits are discarded; the downstream is reset together with this block.
- Throughput: at most one pop per cycle; sustained rate = min(1, credit return rate).

## Test plan
- Reset, then FIFO 2 available with 3 entries: pops at cycles 0,1,2; dn_id=2; credit_cnt 8→5; state returns to IDLE after the last pop.
- All 4 FIFOs always available, MAX_BURST=4, credits refilled every cycle: dn_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,...
- FIFOs 1 and 3 available, MAX_BURST=1: dn_id alternates 1,3,1,3. FIFO 0 becomes available: it is granted within 3 pops.
- INIT_CREDITS=8, no returns, FIFO 0 always available: exactly 8 pops, then dn_valid=0 and credit_cnt=0. One credit_return pulse gives exactly one further pop, issued in the cycle after the return.
- credit_return with no traffic at credit_cnt=8: credit_overflow_error=1 for one cycle, credit_cnt stays 8. Return and pop in the same cycle at credit_cnt=8: no error, count stays 8.
- Reset asserted mid-burst at burst_cnt_q=2 with credit_cnt=3: next cycle dn_valid=0 and credit_cnt=8. The first post-reset grant goes to the lowest available index.
